ofm_reader: RTL and testbench
=============================

OFM_READER -- requirements
Module: ofm_reader

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width of the OFM read port.
REQ-002 Parameter DATA_W, default 8, width of one OFM element.
REQ-003 Parameter LEN_W, default 9, width of the burst length (0..256 elements).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a burst read.
REQ-007 base_addr  input  ADDR_W  first OFM byte address of the burst, sampled with start.
REQ-008 len  input  LEN_W  number of elements to read, sampled with start.
REQ-009 rd_en  output  1  OFM read strobe.
REQ-010 rd_addr  output  ADDR_W  OFM read address, valid when rd_en=1.
REQ-011 rd_data  input  DATA_W  OFM read data, valid exactly 1 cycle after rd_en.
REQ-012 out_data  output  DATA_W  streamed element.
REQ-013 out_valid  output  1  out_data holds a valid element.
REQ-014 out_ready  input  1  consumer accepts; transfer when out_valid and out_ready are both 1.
REQ-015 busy  output  1  high from start acceptance until the done cycle inclusive.
REQ-016 done  output  1  one-cycle pulse after the last element transfers.

Function
REQ-017 FSM states: IDLE, READ, DRAIN, DONE.
REQ-018 IDLE: start=1 latches base_addr/len and goes to READ; if len=0, goes to DONE instead, with no reads and no output.
REQ-019 READ: rd_en=1 in any cycle where issued-not-transferred count (FIFO occupancy + in-flight read) < 2; rd_addr increments by 1 per issued read.
REQ-020 rd_addr wraps modulo 2^ADDR_W (255 -> 0) without error.
REQ-021 READ -> DRAIN in the cycle the len-th read issues; DRAIN -> DONE on the cycle the last element transfers.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE.
REQ-023 First rd_en in the cycle after start; first out_valid 2 cycles after start; under out_ready=1 constant, one element per cycle (throughput 1).
REQ-024 Returned rd_data is captured into a 2-entry FIFO; out_data/out_valid are driven from the FIFO head; elements emerge in address order, none dropped or duplicated.
REQ-025 out_valid, once asserted, stays high and out_data stays stable until transfer.
REQ-026 Simultaneous FIFO push and pop keeps occupancy unchanged.
REQ-027 start while busy=1 is ignored and does not disturb the running burst.
REQ-028 start in the DONE cycle is ignored; start in the first IDLE cycle after DONE is accepted.
REQ-029 Element count is LEN_W wide; len=256 reads addresses base..base+255 mod 256.

Reset
REQ-030 rst=1 on a clock edge forces IDLE, empties FIFO, cancels in-flight read, and clears counters.
REQ-031 Output reset values: rd_en=0, rd_addr=0, out_valid=0, out_data=0, busy=0, done=0.
REQ-032 Reset mid-burst emits no further out_valid and no done; rd_data returning after reset is discarded.

Structure
REQ-033 Shared package ofm_pkg holds ADDR_W, DATA_W, and LEN_W defaults plus the FSM state enumeration.
REQ-034 The 2-entry FIFO is a sub-module, ofm_rd_fifo (push, pop, full, empty, count).
REQ-035 The OFM memory model is outside this block; the bench provides a 1-cycle-latency read model.

Verification
REQ-036 base=0x10, len=4, out_ready=1 -> rd_addr 0x10..0x13 on cycles 1-4, out_data = mem[0x10..0x13] on cycles 2-5, done on cycle 6.
REQ-037 base=0xFE, len=4 -> addresses 0xFE, 0xFF, 0x00, 0x01 in order; 4 outputs; one done.
REQ-038 len=0 -> no rd_en, no out_valid, done on the cycle after start, busy high for 1-2 cycles only.
REQ-039 len=8 with out_ready toggled 1,0,0,1,... -> 8 transfers in order; out_data stable while stalled; never more than 2 outstanding reads.
REQ-040 len=16, rst asserted after the 5th transfer -> all outputs 0 the next cycle; no done; a new start base=0x00, len=2 completes normally.
REQ-041 Second start during a busy len=6 burst -> ignored; exactly 6 outputs and 1 done.

Source files
------------

// File: rtl/ofm_pkg.sv
// Shared defaults and FSM encoding for the OFM burst reader.
package ofm_pkg;

  localparam int unsigned OFM_ADDR_W = 8;
  localparam int unsigned OFM_DATA_W = 8;
  localparam int unsigned OFM_LEN_W  = 9;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } ofm_state_e;

endpackage

// File: rtl/ofm_rd_fifo.sv
// Two-entry FIFO capturing OFM read data; a push and pop on an empty FIFO flow
// straight through without storing.
module ofm_rd_fifo #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic              wr_en;
  logic              rd_adv;

  always_comb begin
    empty   = (count_q == 2'd0);
    full    = (count_q == 2'd2);
    count   = count_q;
    rdata   = mem_q[rd_ptr_q];
    // Empty-FIFO push+pop hands the word to the reader directly
    wr_en   = push && !(empty && pop) && (!full || pop);
    rd_adv  = pop && !empty;
    count_d = count_q + {1'b0, wr_en} - {1'b0, rd_adv};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wdata;
      end
      wr_ptr_q <= wr_ptr_q ^ wr_en;
      rd_ptr_q <= rd_ptr_q ^ rd_adv;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ofm_reader.sv
// Burst reader: issues sequential OFM reads with at most two outstanding and
// streams the returned elements over a valid/ready interface.
module ofm_reader
  import ofm_pkg::*;
#(
  parameter int unsigned ADDR_W = OFM_ADDR_W,
  parameter int unsigned DATA_W = OFM_DATA_W,
  parameter int unsigned LEN_W  = OFM_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  ofm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              inflight_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic [1:0]        outstanding;
  logic              xfer;

  ofm_rd_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_q),
    .wdata(rd_data),
    .pop  (xfer),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_comb begin
    outstanding = fifo_count + {1'b0, inflight_q};
    out_valid   = !fifo_empty || inflight_q;
    out_data    = '0;
    if (!fifo_empty) begin
      out_data = fifo_head;
    end else if (inflight_q) begin
      out_data = rd_data;
    end
    xfer    = out_valid && out_ready;
    rd_en   = (state_q == StRead) && !fifo_full && (outstanding < 2'd2);
    rd_addr = addr_q;
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d   = base_addr;
          remain_d = len;
          state_d  = (len == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        if (rd_en) begin
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == LEN_W'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Only reads already issued remain, so the last one out ends the burst
        if (xfer && (outstanding == 2'd1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      inflight_q <= rd_en;
    end
  end

endmodule

// File: tb/tb_ofm_reader.sv
// Directed and randomized bursts against a queue-based model of the OFM reader.
module tb_ofm_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] len;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_a [$];
  logic [7:0] exp_d [$];
  int         outst = 0;
  int         xfer_cnt = 0;
  int         done_cnt = 0;
  bit         stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  ofm_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // One-cycle-latency OFM memory
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_start(input logic [7:0] b, input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = b + 8'(i);
      exp_a.push_back(a);
      exp_d.push_back(mem[a]);
    end
  endtask

  task automatic monitor();
    if (rst) begin
      stall_prev = 1'b0;
      return;
    end
    if (stall_prev) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_data);
    end
    if (rd_en) begin
      outst++;
      if (exp_a.size() > 0) chk("rd_addr", rd_addr, exp_a.pop_front());
      else chk("extra_rd", rd_en, 0);
      chk("outstanding_le2", (outst <= 2), 1);
    end
    if (out_valid && out_ready) begin
      outst--;
      xfer_cnt++;
      if (exp_d.size() > 0) chk("out_data", out_data, exp_d.pop_front());
      else chk("extra_out", out_valid, 0);
    end
    if (done) begin
      done_cnt++;
      chk("done_pending", exp_d.size(), 0);
    end
    stall_prev = out_valid && !out_ready;
    prev_data  = out_data;
  endtask

  task automatic settle();
    #1;
    monitor();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((c % 3) == 2);
    return ($urandom_range(0, 1) == 1);
  endfunction

  task automatic run_burst(input logic [7:0] b, input logic [8:0] n, input int mode,
                           input int inj, input bit done_start);
    int d0;
    int x0;
    bit seen;
    d0   = done_cnt;
    x0   = xfer_cnt;
    seen = 1'b0;
    model_start(b, int'(n));
    start = 1'b1; base_addr = b; len = n; out_ready = rdy(mode, 0);
    settle();
    chk("idle_at_start", busy, 0);
    tick();
    start = 1'b0;
    for (int c = 1; c < 3000 && !seen; c++) begin
      out_ready = rdy(mode, c);
      if (c == inj) begin
        start = 1'b1; base_addr = 8'($urandom); len = 9'($urandom_range(1, 9));
      end
      settle();
      chk("busy", busy, 1);
      if (c == 1) chk("first_rd", rd_en, (n != 0));
      if (c == 2 && n != 0) chk("first_valid", out_valid, 1);
      if (c == 1 && n == 0) begin
        chk("len0_done", done, 1);
        chk("len0_no_valid", out_valid, 0);
      end
      if (done) begin
        seen = 1'b1;
        if (done_start) begin
          start = 1'b1; base_addr = 8'($urandom); len = 9'd5;
        end
      end
      tick();
      start = 1'b0;
    end
    chk("done_seen", seen, 1);
    chk("xfers", xfer_cnt - x0, int'(n));
    chk("dones", done_cnt - d0, 1);
  endtask

  initial begin
    int x0;
    int d0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rst = 1'b1; start = 1'b0; base_addr = 8'h00; len = 9'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // Exact cycle timing for base 0x10, len 4
    model_start(8'h10, 4);
    start = 1'b1; base_addr = 8'h10; len = 9'd4; out_ready = 1'b1;
    settle();
    chk("t_rd_en0", rd_en, 0);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      settle();
      chk("t_rd_en", rd_en, (c <= 4));
      if (c <= 4) chk("t_rd_addr", rd_addr, 32'h10 + c - 1);
      chk("t_valid", out_valid, (c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) chk("t_data", out_data, mem[8'h0E + c]);
      chk("t_done", done, (c == 6));
      tick();
    end

    run_burst(8'hFE, 9'd4, 0, -1, 1'b0);
    run_burst(8'($urandom), 9'd0, 0, -1, 1'b0);
    run_burst(8'($urandom), 9'd8, 1, -1, 1'b0);

    // Reset after the fifth transfer of a 16-element burst
    x0 = xfer_cnt;
    model_start(8'h40, 16);
    start = 1'b1; base_addr = 8'h40; len = 9'd16; out_ready = 1'b1;
    settle();
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && (xfer_cnt - x0) < 5; c++) begin
      settle();
      tick();
    end
    chk("rst_reach5", xfer_cnt - x0, 5);
    rst = 1'b1; out_ready = 1'b0;
    settle();
    tick();
    rst = 1'b0;
    exp_a.delete();
    exp_d.delete();
    outst = 0;
    d0 = done_cnt;
    chk("mid_rd_en", rd_en, 0);
    chk("mid_rd_addr", rd_addr, 0);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_out_data", out_data, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("post_rst_valid", out_valid, 0);
      tick();
    end
    chk("post_rst_no_done", done_cnt - d0, 0);
    run_burst(8'h00, 9'd2, 0, -1, 1'b0);

    run_burst(8'($urandom), 9'd6, 2, 3, 1'b0);
    run_burst(8'($urandom), 9'd2, 0, -1, 1'b1);
    run_burst(8'($urandom), 9'd3, 2, -1, 1'b0);
    run_burst(8'($urandom), 9'd256, 2, -1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      run_burst(8'($urandom), 9'($urandom_range(1, 20)), int'($urandom_range(0, 2)), -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
